// File: rtl/coproc_cmd_sched.sv
// -----------------------------------------------------------------------------
// coproc_cmd_sched
//
// Command scheduler in front of the image coprocessor. CPU-issued image
// operations are queued in a small FIFO and handed to the coprocessor one at a
// time with a single-cycle start pulse. The next command is only issued after
// the coprocessor reports done, or after the current operation times out.
// The bootloader can claim the image buffer whenever the scheduler is idle.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   cmd_valid/ready   CPU command handshake (cmd_func, cmd_gray, cmd_img_idx)
//   boot_req/gnt      bootloader ownership request / grant
//   cp_rdy, cp_done   coprocessor ready for a new op / op complete pulse
//   cp_start          1-cycle start pulse to the coprocessor
//   cp_func/gray/img_idx  held fields of the current (last issued) command
//   busy              scheduler active or commands still queued
//   q_count           FIFO occupancy
//   timeout_err       sticky hung-operation flag, cleared by err_clr
//   done_cnt          completed-operation counter (wraps)
// -----------------------------------------------------------------------------
module coproc_cmd_sched #(
  parameter int DEPTH = 4,
  parameter int TO_W  = 20,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  input  logic [2:0]                 cmd_func,
  input  logic                       cmd_gray,
  input  logic                       cmd_img_idx,
  output logic                       cmd_ready,
  input  logic                       boot_req,
  output logic                       boot_gnt,
  input  logic                       cp_rdy,
  input  logic                       cp_done,
  output logic                       cp_start,
  output logic [2:0]                 cp_func,
  output logic                       cp_gray,
  output logic                       cp_img_idx,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] q_count,
  output logic                       timeout_err,
  input  logic                       err_clr,
  output logic [CNT_W-1:0]           done_cnt
);

  localparam int QW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [QW-1:0]   DEPTH_Q = QW'(DEPTH);
  // Last timer value before expiry: the op has then spent 2^TO_W-1 cycles in WAIT.
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_BOOT  = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic [QW-1:0]   count_r;
  logic [QW-1:0]   count_next_s;
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [TO_W-1:0] timer_r;
  logic [4:0]      mem_r [DEPTH];
  logic            push_s;
  logic            pop_s;
  logic            done_s;
  logic            expire_s;

  assign q_count = count_r;

  // Next-state, FIFO push/pop and completion/expiry decisions.
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    done_s       = 1'b0;
    expire_s     = 1'b0;
    // Acceptance looks only at the registered occupancy, so a full FIFO
    // refuses a push even when it is popped in the same cycle.
    push_s       = cmd_valid && (count_r < DEPTH_Q);
    case (state_r)
      ST_IDLE: begin
        if (boot_req) begin
          state_next_s = ST_BOOT;
        end else if ((count_r != {QW{1'b0}}) && cp_rdy) begin
          state_next_s = ST_ISSUE;
          pop_s        = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_next_s = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion wins over expiry when both land on the same cycle.
        if (cp_done) begin
          state_next_s = ST_IDLE;
          done_s       = 1'b1;
        end else if (timer_r == TO_LAST) begin
          state_next_s = ST_IDLE;
          expire_s     = 1'b1;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_BOOT: begin
        if (boot_req) begin
          state_next_s = ST_BOOT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
    count_next_s = count_r + QW'(push_s) - QW'(pop_s);
  end

  // FSM, FIFO pointers, timer, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      count_r     <= {QW{1'b0}};
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      timer_r     <= {TO_W{1'b0}};
      cp_start    <= 1'b0;
      cp_func     <= 3'd0;
      cp_gray     <= 1'b0;
      cp_img_idx  <= 1'b0;
      cmd_ready   <= 1'b1;
      boot_gnt    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      done_cnt    <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      count_r <= count_next_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r                          <= rd_ptr_r + PW'(1);
        {cp_func, cp_gray, cp_img_idx}    <= mem_r[rd_ptr_r];
      end
      if (state_r == ST_ISSUE) begin
        timer_r <= {TO_W{1'b0}};
      end else if (state_r == ST_WAIT) begin
        timer_r <= timer_r + TO_W'(1);
      end
      if (done_s) begin
        done_cnt <= done_cnt + CNT_W'(1);
      end
      // Sticky error: a new timeout beats a simultaneous clear.
      if (expire_s) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
      // Outputs are registered from next-state values so they line up with
      // the state they describe.
      cp_start  <= (state_next_s == ST_ISSUE);
      boot_gnt  <= (state_next_s == ST_BOOT);
      busy      <= (state_next_s != ST_IDLE) || (count_next_s != {QW{1'b0}});
      cmd_ready <= (count_next_s < DEPTH_Q);
    end
  end

  // Command storage; entries are only read after being written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {cmd_func, cmd_gray, cmd_img_idx};
    end
  end

endmodule

// File: doc/coproc_cmd_sched.md
Name: coproc_cmd_sched

Overview:
- Command scheduler in front of the image coprocessor.
- Queues CPU-issued image operations (func, gray, img_idx) in a small FIFO and issues them one at a time to the coprocessor with a single-cycle start pulse. Waits for the coprocessor's done before issuing the next command.
- Arbitrates coprocessor/image-buffer ownership between command execution and the bootloader.
- Detects hung operations with a timeout.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, >=2)
- TO_W, 20, timeout counter width; an operation times out after 2^TO_W-1 cycles in WAIT
- CNT_W, 16, completed-operation counter width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  CPU command offer
- cmd_func  in  3  operation code
- cmd_gray  in  1  grayscale select
- cmd_img_idx  in  1  source image select
- cmd_ready  out  1  FIFO can accept a command
- boot_req  in  1  bootloader requests buffer ownership
- boot_gnt  out  1  bootloader owns buffer; coprocessor idle
- cp_rdy  in  1  coprocessor ready for a new op
- cp_done  in  1  coprocessor op complete (1-cycle pulse)
- cp_start  out  1  1-cycle start pulse
- cp_func  out  3  func for current op
- cp_gray  out  1  gray for current op
- cp_img_idx  out  1  img_idx for current op
- busy  out  1  state != IDLE or FIFO non-empty
- q_count  out  $clog2(DEPTH+1)  FIFO occupancy
- timeout_err  out  1  sticky timeout flag
- err_clr  in  1  clears timeout_err
- done_cnt  out  CNT_W  completed ops, wraps at 2^CNT_W

Behaviour:
- Reset (sync, rst=1 at edge) values:
  - All outputs 0 except cmd_ready=1 (after reset).
  - FIFO flushed; state IDLE; timer 0; done_cnt 0; timeout_err 0.
  - Reset mid-operation abandons the op; a later cp_done is ignored because the block is in IDLE.
- FIFO:
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = (q_count < DEPTH), registered occupancy only. A full FIFO refuses a push even when a pop occurs in the same cycle.
  - Simultaneous push+pop on a non-full FIFO leaves q_count unchanged.
  - Pointers wrap modulo DEPTH.
  - Pushes are accepted in every state, including BOOT.
- FSM states: IDLE, ISSUE, WAIT, BOOT.
  - IDLE:
    - boot_req=1 → BOOT (bootloader has priority over queued commands).
    - Else if q_count>0 && cp_rdy → ISSUE; pop the head into held registers cp_func/cp_gray/cp_img_idx.
    - Else stay.
  - ISSUE: cp_start=1 for exactly this cycle; timer cleared; → WAIT.
  - WAIT:
    - Timer increments each cycle.
    - cp_done=1 → IDLE, done_cnt+1.
    - Else if timer == 2^TO_W-2 (i.e. expires this cycle) → timeout_err set, → IDLE; the command is dropped and not retried.
    - cp_done on the expiry cycle counts as completion; no error.
    - boot_req is ignored until IDLE.
  - BOOT: boot_gnt=1 (decoded from state). Stay while boot_req=1; boot_req=0 → IDLE. No cp_start is issued in this state.
- Held command outputs stay stable from ISSUE until the next ISSUE. Their value outside an op is don't-care but deterministic: the last issued command.
- cp_done outside WAIT is ignored: no count, no state change.
- Latency: command pushed at edge N into an empty FIFO with state IDLE and cp_rdy=1 → cp_start high in cycle N+2. Back-to-back commands: cp_done at cycle M → next cp_start at M+2.
- timeout_err: sticky. err_clr clears it. If set and clear occur in the same cycle, set wins.
- busy = (state != IDLE) || (q_count != 0).

Test Plan:
- Single op: reset, push func=3'd2, gray=1, img_idx=1 with cp_rdy=1 → cp_start pulse 2 cycles later with cp_func=2, cp_gray=1, cp_img_idx=1. cp_done 10 cycles later → done_cnt=1, busy=0.
- Fill/order: push 5 commands func=0..4 while cp_rdy=0 → cmd_ready=0 after the 4th, 5th refused, q_count=4. Raise cp_rdy with prompt cp_done responses → issue order func 0,1,2,3; q_count ends 0.
- Boot arbitration: boot_req=1 while in WAIT with 2 queued → boot_gnt stays 0 until cp_done, then 1 on the cycle after IDLE. No cp_start while boot_gnt=1. Drop boot_req → next command issues within 2 cycles.
- Timeout (TO_W=4): issue, never assert cp_done → timeout_err=1 after 15 WAIT cycles; the next queued command issues. err_clr together with a fresh timeout → timeout_err stays 1.
- Corner: cp_done exactly on the expiry cycle → timeout_err=0, done_cnt increments. Stray cp_done in IDLE → no change.
- Reset mid-WAIT with 3 queued → q_count=0, cmd_ready=1, state IDLE. A late cp_done is ignored, done_cnt stays 0.
